// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA scan-out path:
//   - scan_state_t : scan-out FSM state encoding
//   - DEF_*        : default 640x480@60 timing (pixels / lines)
//   - sync_level() : maps "inside sync pulse" to the pin level for a polarity
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DROP = 2'd3
  } scan_state_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // pol = 1 means the pulse is driven high; otherwise it is driven low.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Free-running horizontal/vertical counters with region decode.
// Ports:
//   clk_i         : pixel clock
//   rst_i         : synchronous active-high reset (counters to 0)
//   active_o      : current position is inside the visible area
//   hsync_o       : current position is inside the horizontal sync pulse
//   vsync_o       : current position is inside the vertical sync pulse
//   frame_start_o : raw frame boundary (h = 0, v = 0), not state-qualified
// -----------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic active_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last, v_last;

  // Compare in int so a sync end equal to the total never overflows HW/VW.
  assign h_last = (int'(h_cnt_q) == H_TOTAL - 1);
  assign v_last = (int'(v_cnt_q) == V_TOTAL - 1);

  always_comb begin
    h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active_o      = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
  assign hsync_o       = (int'(h_cnt_q) >= H_SYNC_START) && (int'(h_cnt_q) < H_SYNC_END);
  assign vsync_o       = (int'(v_cnt_q) >= V_SYNC_START) && (int'(v_cnt_q) < V_SYNC_END);
  assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
// Pops one FIFO word per visible pixel and drives registered RGB/sync/DE.
// Ports:
//   clk, rst        : pixel clock, synchronous active-high reset
//   enable          : scan-out enable, acted on at frame boundaries only
//   fifo_read_data  : FIFO head word (valid when fifo_empty = 0)
//   fifo_empty      : FIFO empty flag
//   fifo_pop        : consume head word this cycle (combinational)
//   rgb, de         : registered pixel and data-enable, one cycle after pop
//   hsync, vsync    : registered sync, aligned with rgb/de
//   frame_start     : pulse at the frame boundary whenever not IDLE
//   underrun        : sticky underrun flag; underrun_clr clears it
// -----------------------------------------------------------------------------
module vga_scanout
  import vga_pkg::*;
#(
  parameter int   PIX_W    = 12,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PIX_W-1:0] fifo_read_data,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  output logic [PIX_W-1:0] rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start,
  output logic             underrun,
  input  logic             underrun_clr
);

  logic active, hs_region, vs_region, frame_bnd;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i         (clk),
    .rst_i         (rst),
    .active_o      (active),
    .hsync_o       (hs_region),
    .vsync_o       (vs_region),
    .frame_start_o (frame_bnd)
  );

  scan_state_t state_q, state_d, frame_state;
  logic        run_sel, de_d, underrun_set;

  logic [PIX_W-1:0] rgb_q;
  logic             de_q, hsync_q, vsync_q, underrun_q;

  // frame_state is the state after the frame-boundary decision. Pop and
  // underrun decisions follow it so the first pixel of a frame (h=0, v=0)
  // belongs to the state being entered and is not lost.
  always_comb begin
    frame_state = state_q;
    if (frame_bnd) begin
      if (!enable) begin
        frame_state = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: frame_state = ST_ARM;
          ST_ARM:  frame_state = ST_RUN;
          ST_DROP: frame_state = ST_RUN;
          default: frame_state = state_q;
        endcase
      end
    end
    run_sel      = (frame_state == ST_RUN);
    underrun_set = run_sel && active && fifo_empty;
    de_d         = run_sel && active && !fifo_empty;
    state_d      = underrun_set ? ST_DROP : frame_state;
  end

  assign fifo_pop    = de_d && !rst;
  assign frame_start = frame_bnd && (state_q != ST_IDLE) && !rst;

  // Output stage: everything the pins see is registered here together, so
  // rgb, de, hsync and vsync share the same one-cycle delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rgb_q      <= '0;
      de_q       <= 1'b0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rgb_q      <= fifo_pop ? fifo_read_data : '0;
      de_q       <= de_d;
      hsync_q    <= sync_level(hs_region, SYNC_POL);
      vsync_q    <= sync_level(vs_region, SYNC_POL);
      // A new underrun takes priority over a simultaneous clear.
      if (underrun_set) begin
        underrun_q <= 1'b1;
      end else if (underrun_clr) begin
        underrun_q <= 1'b0;
      end
    end
  end

  assign rgb      = rgb_q;
  assign de       = de_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT A: small timing H 4/1/2/1, V 3/1/1/1 ----------------
  logic        rst_a, en_a, clr_a, empty_a, pop_a, hs_a, vs_a, de_a, fs_a, ur_a;
  logic [11:0] data_a, rgb_a;
  int          seq_a = 0;
  int          limit_a;

  assign empty_a = (seq_a >= limit_a);
  assign data_a  = 12'(seq_a + 'h101);
  always @(posedge clk) if (pop_a) seq_a <= seq_a + 1;

  vga_scanout #(
    .PIX_W(12), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .fifo_read_data(data_a),
    .fifo_empty(empty_a), .fifo_pop(pop_a), .rgb(rgb_a), .hsync(hs_a),
    .vsync(vs_a), .de(de_a), .frame_start(fs_a), .underrun(ur_a),
    .underrun_clr(clr_a)
  );

  // ------------- DUT B: 640-wide lines (800 total), V 3/1/2/1 --------------
  logic        rst_b, en_b, clr_b, empty_b, pop_b, hs_b, vs_b, de_b, fs_b, ur_b;
  logic [11:0] data_b, rgb_b;
  int          seq_b = 0;
  int          limit_b;
  int          cyc_b;

  assign empty_b = (seq_b >= limit_b);
  assign data_b  = 12'(seq_b + 'h101);
  always @(posedge clk) if (pop_b) seq_b <= seq_b + 1;

  vga_scanout #(
    .PIX_W(12), .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .fifo_read_data(data_b),
    .fifo_empty(empty_b), .fifo_pop(pop_b), .rgb(rgb_b), .hsync(hs_b),
    .vsync(vs_b), .de(de_b), .frame_start(fs_b), .underrun(ur_b),
    .underrun_clr(clr_b)
  );

  // Small-timing reference: A pops during the second frame (cycles 48..95).
  function automatic bit a_pops(input int x);
    return (x >= 48) && (x < 96) && ((x % 8) < 4) && (((x / 8) % 6) < 3);
  endfunction

  task automatic tick_b();
    @(negedge clk);
    #1;
    cyc_b++;
  endtask

  task automatic step_b(input int target);
    while (cyc_b < target) tick_b();
  endtask

  initial begin
    int hs_low, vs_low, fs_cnt, pop_cnt, de_cnt, s;
    rst_a = 1'b1; en_a = 1'b1; clr_a = 1'b0; limit_a = 12;
    rst_b = 1'b1; en_b = 1'b1; clr_b = 1'b0; limit_b = 645;
    cyc_b = 0;

    // ---- A: reset values while FIFO is non-empty and enable is high ----
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_pop",   32'(pop_a), 32'd0);
    check_eq("rst_rgb",   32'(rgb_a), 32'd0);
    check_eq("rst_de",    32'(de_a),  32'd0);
    check_eq("rst_hsync", 32'(hs_a),  32'd1);
    check_eq("rst_vsync", 32'(vs_a),  32'd1);
    check_eq("rst_fs",    32'(fs_a),  32'd0);
    check_eq("rst_ur",    32'(ur_a),  32'd0);

    // ---- A: two frames, first ARM (dark), second RUN (12 pixels) ----
    @(negedge clk);
    rst_a = 1'b0;
    for (int c = 0; c < 96; c++) begin
      bit          prev_pop;
      logic [11:0] exp_rgb;
      int          pc, ph, pv;
      #1;
      prev_pop = (c >= 1) && a_pops(c - 1);
      exp_rgb  = prev_pop ? 12'((((c - 1 - 48) / 8) * 4) + ((c - 1) % 8) + 'h101) : 12'd0;
      check_eq($sformatf("a_fs@%0d", c),  32'(fs_a),  (c == 48) ? 32'd1 : 32'd0);
      check_eq($sformatf("a_pop@%0d", c), 32'(pop_a), a_pops(c) ? 32'd1 : 32'd0);
      check_eq($sformatf("a_rgb@%0d", c), 32'(rgb_a), 32'(exp_rgb));
      check_eq($sformatf("a_de@%0d", c),  32'(de_a),  prev_pop ? 32'd1 : 32'd0);
      if (c == 0) begin
        check_eq("a_hs@0", 32'(hs_a), 32'd1);
        check_eq("a_vs@0", 32'(vs_a), 32'd1);
      end else begin
        pc = c - 1; ph = pc % 8; pv = (pc / 8) % 6;
        check_eq($sformatf("a_hs@%0d", c), 32'(hs_a), (ph >= 5 && ph < 7) ? 32'd0 : 32'd1);
        check_eq($sformatf("a_vs@%0d", c), 32'(vs_a), (pv == 4) ? 32'd0 : 32'd1);
      end
      @(negedge clk);
    end
    check_eq("a_words_popped", 32'(seq_a), 32'd12);
    rst_a = 1'b1;

    // ---- B: sync widths during the first (IDLE/ARM) frame ----
    rst_b = 1'b0;
    #1;
    cyc_b = 0;
    hs_low = 0; vs_low = 0; fs_cnt = 0; pop_cnt = 0;
    while (cyc_b < 5600) begin
      if (cyc_b < 800 && !hs_b) hs_low++;
      if (!vs_b) vs_low++;
      if (fs_b) fs_cnt++;
      if (pop_b) pop_cnt++;
      tick_b();
    end
    check_eq("b_hsync_low_per_line",  32'(hs_low),  32'd96);
    check_eq("b_vsync_low_per_frame", 32'(vs_low),  32'd1600);
    check_eq("b_fs_in_first_frame",   32'(fs_cnt),  32'd0);
    check_eq("b_pops_in_arm",         32'(pop_cnt), 32'd0);
    check_eq("b_fs_arm_to_run",       32'(fs_b),    32'd1);
    check_eq("b_pop_first_pixel",     32'(pop_b),   32'd1);

    // ---- B: FIFO empty at pixel 5 of line 1 ----
    step_b(6405);
    check_eq("b_pop_at_underrun", 32'(pop_b), 32'd0);
    check_eq("b_words_before_ur", 32'(seq_b), 32'd645);
    check_eq("b_ur_not_yet",      32'(ur_b),  32'd0);
    tick_b();
    check_eq("b_ur_set",     32'(ur_b),          32'd1);
    check_eq("b_ur_de",      32'(de_b),          32'd0);
    check_eq("b_ur_rgb",     32'(rgb_b),         32'd0);
    check_eq("b_state_drop", 32'(dut_b.state_q), 32'(ST_DROP));
    de_cnt = 0; pop_cnt = 0; fs_cnt = 0;
    while (cyc_b < 11200) begin
      if (de_b) de_cnt++;
      if (pop_b) pop_cnt++;
      if (fs_b) fs_cnt++;
      if (cyc_b == 7000) limit_b = 1000000;
      tick_b();
    end
    check_eq("b_drop_de",  32'(de_cnt),  32'd0);
    check_eq("b_drop_pop", 32'(pop_cnt), 32'd0);
    check_eq("b_drop_fs",  32'(fs_cnt),  32'd0);
    check_eq("b_fs_drop_to_run",  32'(fs_b),  32'd1);
    check_eq("b_pop_after_drop",  32'(pop_b), 32'd1);
    tick_b();
    check_eq("b_state_run_again", 32'(dut_b.state_q), 32'(ST_RUN));
    check_eq("b_de_run_again",    32'(de_b),          32'd1);
    check_eq("b_rgb_run_again",   32'(rgb_b),         32'h386);

    // ---- B: clear coinciding with a new underrun, then clear alone ----
    limit_b = 745;
    step_b(11300);
    check_eq("b_words_frame3", 32'(seq_b), 32'd745);
    check_eq("b_pop_ur2",      32'(pop_b), 32'd0);
    clr_b = 1'b1;
    tick_b();
    clr_b = 1'b0;
    check_eq("b_set_beats_clr", 32'(ur_b), 32'd1);
    step_b(11305);
    clr_b = 1'b1;
    tick_b();
    clr_b = 1'b0;
    check_eq("b_clr_alone", 32'(ur_b), 32'd0);
    limit_b = 1000000;

    // ---- B: enable dropped mid-frame ----
    step_b(17800);
    en_b = 1'b0;
    step_b(19039);
    check_eq("b_pop_last_pixel", 32'(pop_b), 32'd1);
    tick_b();
    check_eq("b_de_last_pixel",  32'(de_b),  32'd1);
    check_eq("b_pop_hblank",     32'(pop_b), 32'd0);
    step_b(22400);
    check_eq("b_pop_at_disable_bnd", 32'(pop_b), 32'd0);
    tick_b();
    check_eq("b_state_idle", 32'(dut_b.state_q), 32'(ST_IDLE));
    de_cnt = 0; pop_cnt = 0; fs_cnt = 0;
    while (cyc_b <= 28000) begin
      if (de_b) de_cnt++;
      if (pop_b) pop_cnt++;
      if (fs_b) fs_cnt++;
      tick_b();
    end
    check_eq("b_idle_fs",  32'(fs_cnt),  32'd0);
    check_eq("b_idle_pop", 32'(pop_cnt), 32'd0);
    check_eq("b_idle_de",  32'(de_cnt),  32'd0);

    // ---- B: re-enable, then one-cycle reset at h=300, v=1 of a RUN frame ----
    en_b = 1'b1;
    step_b(40300);
    check_eq("b_de_before_rst", 32'(de_b), 32'd1);
    s = seq_b;
    rst_b = 1'b1;
    #1;
    check_eq("b_pop_in_rst", 32'(pop_b), 32'd0);
    tick_b();
    rst_b = 1'b0;
    check_eq("b_rst_hcnt",  32'(dut_b.u_timing.h_cnt_q), 32'd0);
    check_eq("b_rst_vcnt",  32'(dut_b.u_timing.v_cnt_q), 32'd0);
    check_eq("b_rst_state", 32'(dut_b.state_q),          32'(ST_IDLE));
    check_eq("b_rst_rgb",   32'(rgb_b), 32'd0);
    check_eq("b_rst_de",    32'(de_b),  32'd0);
    check_eq("b_rst_hsync", 32'(hs_b),  32'd1);
    check_eq("b_rst_vsync", 32'(vs_b),  32'd1);
    check_eq("b_rst_fifo_untouched", 32'(seq_b), 32'(s));

    // ---- B: reset while both syncs are asserted ----
    cyc_b = 0;
    step_b(3901);
    check_eq("b_hsync_in_pulse", 32'(hs_b), 32'd0);
    check_eq("b_vsync_in_pulse", 32'(vs_b), 32'd0);
    rst_b = 1'b1;
    tick_b();
    rst_b = 1'b0;
    check_eq("b_rst2_hsync", 32'(hs_b), 32'd1);
    check_eq("b_rst2_vsync", 32'(vs_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
